// File: rtl/operand_loader.sv
`default_nettype none
// ============================================================================
// Module      : operand_loader
// Description : Front-end input stage of the adder datapath. Builds two
//               WIDTH-bit operands (dataA, dataB) from 8-bit switch data,
//               one byte per accepted "enter" press, most-significant byte
//               first, and raises inputdata_ready once both are complete.
//               In view mode (loaddata=0) each accepted press advances a
//               result-byte selector used by the display peripherals.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   WIDTH     operand width in bits, a multiple of 8 (BYTES = WIDTH/8)
//   DEBOUNCE  cycles the synchronized enter level must remain stable before
//             it is believed; 0 disables the debounce filter
// Ports
//   clk              in   1      system clock, rising edge
//   reset            in   1      asynchronous, active-low reset
//   enter            in   1      raw pushbutton, asynchronous, active-high
//   inputdata        in   8      byte to load (switches)
//   loaddata         in   1      1 = load mode, 0 = view mode
//   dataA            out  WIDTH  operand A to adder
//   dataB            out  WIDTH  operand B to adder
//   inputdata_ready  out  1      both operands fully loaded
//   byte_idx         out  IDX_W  next byte slot to fill (0 = MSB)
//   loading_b        out  1      0 = filling A, 1 = filling B
//   view_sel         out  IDX_W  result byte selected for display (0 = MSB)
// ============================================================================
module operand_loader #(
  parameter int WIDTH    = 32,
  parameter int DEBOUNCE = 0,
  localparam int BYTES   = WIDTH / 8,
  localparam int IDX_W   = (BYTES > 1) ? $clog2(BYTES) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enter,
  input  logic [7:0]       inputdata,
  input  logic             loaddata,
  output logic [WIDTH-1:0] dataA,
  output logic [WIDTH-1:0] dataB,
  output logic             inputdata_ready,
  output logic [IDX_W-1:0] byte_idx,
  output logic             loading_b,
  output logic [IDX_W-1:0] view_sel
);

  localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(BYTES - 1);
  localparam logic [IDX_W-1:0] c_IDX_ONE  = IDX_W'(1);

  typedef enum logic [1:0] {
    S_LOAD_A = 2'd0,
    S_LOAD_B = 2'd1,
    S_READY  = 2'd2
  } state_t;

  state_t r_state;

  // --------------------------------------------------------------------------
  // enter conditioning: 2-FF synchronizer, optional debounce, rising edge.
  // --------------------------------------------------------------------------
  logic r_enter_meta;
  logic r_enter_sync;
  logic r_level_prev;
  logic w_level;
  logic w_accept;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_enter_meta <= 1'b0;
      r_enter_sync <= 1'b0;
    end else begin
      r_enter_meta <= enter;
      r_enter_sync <= r_enter_meta;
    end
  end

  generate
    if (DEBOUNCE == 0) begin : g_no_debounce
      assign w_level = r_enter_sync;
    end else begin : g_debounce
      localparam int c_CNT_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
      localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE - 1);

      logic               r_deb_level;
      logic [c_CNT_W-1:0] r_deb_cnt;

      // The filtered level only follows the synchronized level after it has
      // disagreed with it for DEBOUNCE consecutive cycles; any glitch back
      // to the filtered value restarts the count.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          r_deb_level <= 1'b0;
          r_deb_cnt   <= '0;
        end else if (r_enter_sync == r_deb_level) begin
          r_deb_cnt <= '0;
        end else if (r_deb_cnt == c_CNT_LAST) begin
          r_deb_level <= r_enter_sync;
          r_deb_cnt   <= '0;
        end else begin
          r_deb_cnt <= r_deb_cnt + c_CNT_W'(1);
        end
      end

      assign w_level = r_deb_level;
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_level_prev <= 1'b0;
    end else begin
      r_level_prev <= w_level;
    end
  end

  // One-cycle pulse per press; a held button stays high in w_level and
  // r_level_prev, so it cannot retrigger.
  assign w_accept = w_level & ~r_level_prev;

  // --------------------------------------------------------------------------
  // Operand shift values. Shifting by 8 drops the oldest top byte and keeps
  // the expression valid for any WIDTH that is a multiple of 8.
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0] w_shift_a;
  logic [WIDTH-1:0] w_shift_b;
  logic [WIDTH-1:0] w_first_byte;

  assign w_shift_a    = (dataA << 8) | WIDTH'(inputdata);
  assign w_shift_b    = (dataB << 8) | WIDTH'(inputdata);
  assign w_first_byte = WIDTH'(inputdata);

  // --------------------------------------------------------------------------
  // Load / view state machine. All outputs are registered here and only move
  // on an accept edge. View-mode accepts touch view_sel alone, so a partial
  // load simply waits for the return to load mode.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state         <= S_LOAD_A;
      dataA           <= '0;
      dataB           <= '0;
      inputdata_ready <= 1'b0;
      byte_idx        <= '0;
      loading_b       <= 1'b0;
      view_sel        <= '0;
    end else if (w_accept) begin
      if (!loaddata) begin
        view_sel <= (view_sel == c_LAST_IDX) ? '0 : view_sel + c_IDX_ONE;
      end else begin
        case (r_state)
          S_LOAD_A: begin
            dataA <= w_shift_a;
            if (byte_idx == c_LAST_IDX) begin
              byte_idx  <= '0;
              loading_b <= 1'b1;
              r_state   <= S_LOAD_B;
            end else begin
              byte_idx <= byte_idx + c_IDX_ONE;
            end
          end
          S_LOAD_B: begin
            dataB <= w_shift_b;
            if (byte_idx == c_LAST_IDX) begin
              byte_idx        <= '0;
              loading_b       <= 1'b0;
              inputdata_ready <= 1'b1;
              r_state         <= S_READY;
            end else begin
              byte_idx <= byte_idx + c_IDX_ONE;
            end
          end
          S_READY: begin
            // The press that follows a completed pair is the first byte of
            // the next operand A; the old pair is discarded.
            dataA           <= w_first_byte;
            dataB           <= '0;
            inputdata_ready <= 1'b0;
            loading_b       <= 1'b0;
            if (BYTES == 1) begin
              byte_idx  <= '0;
              loading_b <= 1'b1;
              r_state   <= S_LOAD_B;
            end else begin
              byte_idx <= c_IDX_ONE;
              r_state  <= S_LOAD_A;
            end
          end
          default: begin
            r_state <= S_LOAD_A;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_operand_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_operand_loader
// Description : Self-checking bench for operand_loader (WIDTH=32, no
//               debounce). Vector table, directed corner sequences and a
//               randomized run against a byte-list reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_operand_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enter = 1'b0;
  logic [7:0]  inputdata = 8'h00;
  logic        loaddata = 1'b1;
  logic [31:0] dataA;
  logic [31:0] dataB;
  logic        inputdata_ready;
  logic [1:0]  byte_idx;
  logic        loading_b;
  logic [1:0]  view_sel;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  operand_loader #(.WIDTH(32), .DEBOUNCE(0)) dut (
    .clk             (clk),
    .reset           (reset),
    .enter           (enter),
    .inputdata       (inputdata),
    .loaddata        (loaddata),
    .dataA           (dataA),
    .dataB           (dataB),
    .inputdata_ready (inputdata_ready),
    .byte_idx        (byte_idx),
    .loading_b       (loading_b),
    .view_sel        (view_sel)
  );

  // --------------------------------------------------------------------------
  // Reference model: the list of bytes entered in the current load session
  // plus a view counter. Operands are rebuilt from the list arithmetically.
  // --------------------------------------------------------------------------
  int         m_n;
  logic [7:0] m_bytes [8];
  int         m_view;

  function automatic logic [31:0] m_operand(input int base);
    logic [31:0] v = 32'h0;
    for (int i = 0; i < 4; i++)
      if (base + i < m_n) v = v * 256 + 32'(m_bytes[base + i]);
    return v;
  endfunction

  task automatic m_press(input logic [7:0] d, input logic load);
    if (load) begin
      if (m_n == 8) m_n = 0;
      m_bytes[m_n] = d;
      m_n++;
    end else begin
      m_view = (m_view + 1) % 4;
    end
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] ea, input logic [31:0] eb,
                         input logic er, input logic [1:0] ei, input logic el,
                         input logic [1:0] ev);
    chk($sformatf("%s.dataA", tag), 64'(dataA), 64'(ea));
    chk($sformatf("%s.dataB", tag), 64'(dataB), 64'(eb));
    chk($sformatf("%s.ready", tag), 64'(inputdata_ready), 64'(er));
    chk($sformatf("%s.byte_idx", tag), 64'(byte_idx), 64'(ei));
    chk($sformatf("%s.loading_b", tag), 64'(loading_b), 64'(el));
    chk($sformatf("%s.view_sel", tag), 64'(view_sel), 64'(ev));
  endtask

  task automatic m_check(input string tag);
    chk_all(tag, m_operand(0), m_operand(4), m_n == 8, 2'(m_n % 4),
            (m_n >= 4) && (m_n < 8), 2'(m_view));
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    enter = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    m_n    = 0;
    m_view = 0;
  endtask

  // One press: enter high for 'hold' cycles, then enough idle cycles for the
  // action edge to pass and the edge detector to re-arm.
  task automatic press(input logic [7:0] d, input logic load, input int hold);
    @(negedge clk);
    inputdata = d;
    loaddata  = load;
    enter     = 1'b1;
    repeat (hold) @(negedge clk);
    enter = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  typedef struct {
    logic [7:0]  din;
    logic        load;
    int          hold;
    logic [31:0] ea;
    logic [31:0] eb;
    logic        er;
    logic [1:0]  ei;
    logic        el;
    logic [1:0]  ev;
  } vec_t;

  vec_t tbl [10];

  initial begin
    logic [7:0] seq1 [8];
    logic [7:0] d;
    logic       ld;

    // Continues from the READY state left by the latency sequence below.
    tbl[0] = '{8'h55, 1'b0, 1,  32'h40E00000, 32'hC0E01000, 1'b1, 2'd0, 1'b0, 2'd1};
    tbl[1] = '{8'h66, 1'b0, 1,  32'h40E00000, 32'hC0E01000, 1'b1, 2'd0, 1'b0, 2'd2};
    tbl[2] = '{8'h77, 1'b0, 2,  32'h40E00000, 32'hC0E01000, 1'b1, 2'd0, 1'b0, 2'd3};
    tbl[3] = '{8'h88, 1'b0, 1,  32'h40E00000, 32'hC0E01000, 1'b1, 2'd0, 1'b0, 2'd0};
    tbl[4] = '{8'h99, 1'b0, 1,  32'h40E00000, 32'hC0E01000, 1'b1, 2'd0, 1'b0, 2'd1};
    tbl[5] = '{8'h3F, 1'b1, 1,  32'h0000003F, 32'h00000000, 1'b0, 2'd1, 1'b0, 2'd1};
    tbl[6] = '{8'hAB, 1'b1, 10, 32'h00003FAB, 32'h00000000, 1'b0, 2'd2, 1'b0, 2'd1};
    tbl[7] = '{8'hCD, 1'b0, 3,  32'h00003FAB, 32'h00000000, 1'b0, 2'd2, 1'b0, 2'd2};
    tbl[8] = '{8'h12, 1'b1, 2,  32'h003FAB12, 32'h00000000, 1'b0, 2'd3, 1'b0, 2'd2};
    tbl[9] = '{8'h34, 1'b1, 1,  32'h3FAB1234, 32'h00000000, 1'b0, 2'd0, 1'b1, 2'd2};

    seq1[0] = 8'h40; seq1[1] = 8'hE0; seq1[2] = 8'h00; seq1[3] = 8'h00;
    seq1[4] = 8'hC0; seq1[5] = 8'hE0; seq1[6] = 8'h10; seq1[7] = 8'h00;

    m_n = 0;
    m_view = 0;

    // Reset state
    repeat (3) @(negedge clk);
    chk_all("reset", 32'h0, 32'h0, 1'b0, 2'd0, 1'b0, 2'd0);
    reset = 1'b1;
    @(negedge clk);

    // Full load with exact latency of the final byte
    for (int i = 0; i < 7; i++) begin
      press(seq1[i], 1'b1, 1);
      m_press(seq1[i], 1'b1);
    end
    m_check("seq1_pre");
    @(negedge clk);
    inputdata = seq1[7];
    enter     = 1'b1;
    @(posedge clk);                 // edge k: first sample of enter
    #1 chk("lat_k.ready", 64'(inputdata_ready), 64'd0);
    @(negedge clk);
    enter = 1'b0;
    @(posedge clk);                 // edge k+1
    #1 chk("lat_k1.ready", 64'(inputdata_ready), 64'd0);
    chk("lat_k1.dataB", 64'(dataB), 64'h00C0E010);
    @(posedge clk);                 // edge k+2: action
    #1 chk("lat_k2.ready", 64'(inputdata_ready), 64'd1);
    chk("lat_k2.dataB", 64'(dataB), 64'hC0E01000);
    repeat (3) @(negedge clk);
    m_press(seq1[7], 1'b1);
    chk_all("seq1", 32'h40E00000, 32'hC0E01000, 1'b1, 2'd0, 1'b0, 2'd0);

    // Vector table
    for (int i = 0; i < 10; i++) begin
      press(tbl[i].din, tbl[i].load, tbl[i].hold);
      m_press(tbl[i].din, tbl[i].load);
      chk_all($sformatf("vec%0d", i), tbl[i].ea, tbl[i].eb, tbl[i].er,
              tbl[i].ei, tbl[i].el, tbl[i].ev);
    end

    // Held enter from reset: exactly one byte
    do_reset();
    press(8'hAB, 1'b1, 10);
    m_press(8'hAB, 1'b1);
    chk("hold.dataA", 64'(dataA), 64'h000000AB);
    chk("hold.byte_idx", 64'(byte_idx), 64'd1);

    // Mode switch in the middle of a load
    do_reset();
    press(8'h11, 1'b1, 1);
    press(8'h22, 1'b1, 1);
    press(8'h99, 1'b0, 1);
    press(8'h33, 1'b1, 1);
    press(8'h44, 1'b1, 1);
    chk_all("modesw", 32'h11223344, 32'h0, 1'b0, 2'd0, 1'b1, 2'd1);

    // Asynchronous reset mid-LOAD_B, between clock edges
    do_reset();
    for (int i = 0; i < 6; i++) press(8'(8'hA0 + i), 1'b1, 1);
    chk("midb.loading_b", 64'(loading_b), 64'd1);
    @(posedge clk);
    #2 reset = 1'b0;
    #1 chk_all("async_rst", 32'h0, 32'h0, 1'b0, 2'd0, 1'b0, 2'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    m_n = 0;
    m_view = 0;
    @(negedge clk);
    press(8'h11, 1'b1, 1);
    m_press(8'h11, 1'b1);
    chk("post_rst.dataA", 64'(dataA), 64'h00000011);
    m_check("post_rst");

    // Randomized presses against the model
    do_reset();
    for (int i = 0; i < 80; i++) begin
      d  = 8'($urandom);
      ld = ($urandom_range(0, 3) != 0);
      press(d, ld, int'($urandom_range(1, 5)));
      m_press(d, ld);
      m_check($sformatf("rand%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
